// File: rtl/systolic_operand_feeder_pkg.sv
// Shared constants, FSM states and index helper
// for the systolic array operand feeder.
package systolic_operand_feeder_pkg;

  localparam int N          = 4;
  localparam int STREAM_LEN = 2 * N - 1;
  localparam int DRAIN_LEN  = N;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;

  // Flat element index: row*N + col.
  function automatic logic [3:0] elem_idx(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/systolic_operand_feeder_bank.sv
// 16-entry operand register file with one write
// port and four diagonally skewed read taps.
module feeder_operand_bank
  import systolic_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit COL_MAJOR  = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              we_i,
  input  logic [3:0]                        waddr_i,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  input  logic                              en_i,
  input  logic [2:0]                        t_i,
  output logic [N-1:0][DATA_WIDTH-1:0]      tap_o
);

  logic [15:0][DATA_WIDTH-1:0] mem_q;
  logic [15:0][DATA_WIDTH-1:0] mem_d;

  // Single write port; contents persist across runs.
  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
  end

  // Storage, cleared on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  // Lane l is skewed by l steps; outside the
  // 4-wide window the tap is forced to zero.
  for (genvar l = 0; l < N; l++) begin : g_tap
    logic [3:0] diff;
    logic       in_rng;
    logic [3:0] idx;

    assign diff   = {1'b0, t_i} - 4'(l);
    assign in_rng = en_i && (diff[3:2] == 2'b00);

    if (COL_MAJOR) begin : g_col
      assign idx = elem_idx(diff[1:0], 2'(l));
    end else begin : g_row
      assign idx = elem_idx(2'(l), diff[1:0]);
    end

    assign tap_o[l] = in_rng ? mem_q[idx] : '0;
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Buffers A/B matrices and drives the skewed
// left/up operand streams of the 4x4 array.
module systolic_operand_feeder
  import systolic_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic                  wr_sel_i,
  input  logic [3:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  arr_clr_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] left_o_0,
  output logic [DATA_WIDTH-1:0] left_o_1,
  output logic [DATA_WIDTH-1:0] left_o_2,
  output logic [DATA_WIDTH-1:0] left_o_3,
  output logic [DATA_WIDTH-1:0] up_o_0,
  output logic [DATA_WIDTH-1:0] up_o_1,
  output logic [DATA_WIDTH-1:0] up_o_2,
  output logic [DATA_WIDTH-1:0] up_o_3
);

  feeder_state_e state_q, state_d;
  logic [2:0]    t_q, t_d;
  logic          busy_q, busy_d;
  logic          clr_q, clr_d;
  logic          done_q, done_d;
  logic [N-1:0][DATA_WIDTH-1:0] left_q, left_d;
  logic [N-1:0][DATA_WIDTH-1:0] up_q, up_d;

  logic wr_en;
  logic rd_en;

  assign wr_en = wr_valid_i && (state_q == ST_IDLE);
  assign rd_en = (state_d == ST_STREAM);

  // Taps are addressed with the next-state step so
  // the operand registers line up with the state.
  feeder_operand_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .COL_MAJOR  (1'b0)
  ) u_bank_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en && !wr_sel_i),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .en_i    (rd_en),
    .t_i     (t_d),
    .tap_o   (left_d)
  );

  feeder_operand_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .COL_MAJOR  (1'b1)
  ) u_bank_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en && wr_sel_i),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .en_i    (rd_en),
    .t_i     (t_d),
    .tap_o   (up_d)
  );

  // Next-state and step counter sequencing.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      ST_IDLE: begin
        t_d = '0;
        if (start_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_STREAM;
        t_d     = '0;
      end
      ST_STREAM: begin
        if (t_q == 3'(STREAM_LEN - 1)) begin
          state_d = ST_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (t_q == 3'(DRAIN_LEN - 1)) begin
          state_d = ST_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Status outputs decoded from the next state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    clr_d  = (state_d == ST_CLEAR);
    done_d = (state_d == ST_DONE);
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
      up_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      left_q  <= left_d;
      up_q    <= up_d;
    end
  end

  assign busy_o     = busy_q;
  assign wr_ready_o = !busy_q;
  assign arr_clr_o  = clr_q;
  assign done_o     = done_q;
  assign left_o_0   = left_q[0];
  assign left_o_1   = left_q[1];
  assign left_o_2   = left_q[2];
  assign left_o_3   = left_q[3];
  assign up_o_0     = up_q[0];
  assign up_o_1     = up_q[1];
  assign up_o_2     = up_q[2];
  assign up_o_3     = up_q[3];

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
Front-end driver for the 4x4 systolic multiply array. It buffers a 4x4 A matrix and a 4x4 B matrix through a simple write port. On start it issues a one-cycle array clear, then drives the diagonally skewed left-edge (A rows) and top-edge (B columns) operand streams the array consumes. It then flushes zeros until the last PE has accumulated, and pulses done_o. It is the producer side of the array's left/up operand interface.

Parameters:
DATA_WIDTH, 32, width of each matrix element and of every left/up operand output.
N, 4, array dimension; fixed at 4 for this revision, and the port list is written out for 4.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
wr_valid_i  input  1  matrix element write request
wr_ready_o  output  1  high only in IDLE; write accepted when wr_valid_i && wr_ready_o
wr_sel_i  input  1  0 = write A bank, 1 = write B bank
wr_addr_i  input  4  element index = row*4 + col
wr_data_i  input  DATA_WIDTH  element value
start_i  input  1  begin a multiply; sampled only in IDLE
busy_o  output  1  high in every state except IDLE
arr_clr_o  output  1  one-cycle clear pulse to the array accumulators
done_o  output  1  one-cycle pulse; array results valid this cycle
left_o_0..left_o_3  output  DATA_WIDTH each  left-edge operands, rows 0..3
up_o_0..up_o_3  output  DATA_WIDTH each  top-edge operands, columns 0..3

Behaviour:
- Reset (async, any state):
  - state to IDLE.
  - All left_o/up_o = 0; arr_clr_o, done_o, busy_o = 0; wr_ready_o = 1 once released.
  - Both banks cleared to 0.
  - Reset mid-stream aborts with no done_o.
- All outputs are registered. The FSM has states IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - wr_valid_i writes bank[wr_sel_i][wr_addr_i] at the edge.
  - start_i high at edge k moves to CLEAR.
  - A write and start at the same edge: the write takes effect and the stream uses the new value.
- CLEAR (cycle k+1):
  - arr_clr_o = 1; all operand outputs 0.
  - Lasts 1 cycle, then STREAM with step counter t = 0.
- STREAM (cycles k+2 .. k+8, t = 0..6):
  - left_o_r = A[r][t-r] if 0 <= t-r <= 3, else 0.
  - up_o_c = B[t-c][c] if 0 <= t-c <= 3, else 0.
  - After t = 6, go to DRAIN.
- DRAIN (cycles k+9 .. k+12, 4 cycles):
  - All operand outputs 0.
  - A[3][3]/B[3][3] reach PE15 at t = 9, and its accumulation registers at t = 10.
- DONE (cycle k+13):
  - done_o = 1 for exactly one cycle; operand outputs 0.
  - Next state IDLE.
- Handshake rules:
  - wr_ready_o = !busy_o.
  - Writes while busy are dropped and the banks are unchanged.
  - start_i while busy is ignored, with no queuing.
  - Back-to-back start: the earliest next start edge is the cycle after DONE, at k+14 relative to the first.
- Bank contents persist across multiplies. Re-start without rewriting replays the same matrices.
- No arithmetic in this block. Out-of-range skew slots drive exact zero, so the array accumulates no spurious products.

Decomposition:
- Shared package contains:
  - Constants N = 4, STREAM_LEN = 2*N-1 = 7, DRAIN_LEN = N = 4.
  - The FSM state enumeration.
  - Element index helper (row*N + col).
- One natural sub-module: feeder_operand_bank. It is a 16 x DATA_WIDTH register file with one write port and four parallel skewed read taps, indexed by t and lane. It is instantiated twice: A with row-major taps, B with column-major taps.
- FSM and step counter live in the top.

Test Plan:
- Reset while idle: rst_i pulse -> all outputs 0, wr_ready_o = 1, banks read 0 (start yields an all-zero stream and done_o at k+13).
- Load A = identity, B[i][j] = 4*i + j + 1, start at edge k:
  - arr_clr_o high only at k+1.
  - At k+2: left_o_0 = 1, up_o_0 = 1, other lanes 0.
  - At k+5: up_o_3 = 4, left_o_3 = 0.
  - done_o at k+13; array results equal B.
- Skew check with A[r][c] = 16 + 4r + c, B[r][c] = 32 + 4r + c: at t = 3, left = {19, 22, 25, 28} and up = {44, 41, 38, 35}; at t = 6 only left_o_3 = 31 and up_o_3 = 47 are nonzero.
- Busy protection: start while streaming, plus wr_valid_i writing A[0][0] = 99 -> no restart, wr_ready_o = 0, single done_o, next multiply still uses the old A[0][0].
- Simultaneous write and start in IDLE with A[0][0] = 7 -> left_o_0 = 7 at k+2.
- Reset asserted at k+5 mid-stream -> outputs 0 immediately (asynchronous), no done_o, IDLE after release, banks 0.
